// File: rtl/ahb_dma_master_if.sv
// AHB-Lite bus bundle between the DMA master and the CoreSystemDMA_slave port.
// Latency: none, this is wiring only.
// Backpressure: the slave stalls the master through HREADY; HRESP reports errors.
// Ports: master drives HADDR/HTRANS/HBURST/HSIZE/HWRITE/HWDATA and samples
// HREADY/HRDATA/HRESP. The slave modport is the mirror image.
interface ahb_dma_master_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;  // 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
  logic [2:0]        HBURST;  // 000 SINGLE, 001 INCR
  logic [2:0]        HSIZE;
  logic              HWRITE;
  logic [31:0]       HWDATA;
  logic              HREADY;  // slave HREADYOUT
  logic [31:0]       HRDATA;
  logic              HRESP;   // 0 OKAY, 1 ERROR

  modport master (
    output HADDR, HTRANS, HBURST, HSIZE, HWRITE, HWDATA,
    input  HREADY, HRDATA, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HBURST, HSIZE, HWRITE, HWDATA,
    output HREADY, HRDATA, HRESP
  );
endinterface

// File: rtl/ahb_dma_master.sv
// AHB-Lite DMA master: turns word-transfer commands into pipelined SINGLE/INCR bursts.
// Latency: first address phase one cycle after command accept; done two cycles after the last address phase.
// Backpressure: cmd_ready only in IDLE; HREADY=0 freezes every bus output and counter.
// Ports: HCLK/HRESETn (sync, active-low); cmd_* request port; pause asks for BUSY
// cycles in INCR bursts; wr_data/wr_pop local write source; rd_data/rd_valid read
// return; done/err completion; bus = AHB master modport.
module ahb_dma_master #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_write,
  input  logic              cmd_incr,
  input  logic              pause,
  input  logic [31:0]       wr_data,
  output logic              wr_pop,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  ahb_dma_master_if.master  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_BURST = 3'd2;
  localparam logic [2:0] S_LAST  = 3'd3;
  localparam logic [2:0] S_ERR1  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  logic [2:0]        state_q,    state_d;
  logic [ADDR_W-1:0] haddr_q,    haddr_d;
  logic [1:0]        htrans_q,   htrans_d;
  logic [2:0]        hburst_q,   hburst_d;
  logic              hwrite_q,   hwrite_d;
  logic [31:0]       hwdata_q,   hwdata_d;
  logic [LEN_W-1:0]  rem_q,      rem_d;     // beats whose address phase is not yet accepted
  logic              incr_q,     incr_d;
  logic              dph_q,      dph_d;     // a beat is in its data phase
  logic [31:0]       rd_data_q,  rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q,     done_d;
  logic              err_q,      err_d;

  logic              in_xfer;
  logic              accept;
  logic              err_first;
  logic [ADDR_W-1:0] next_addr;
  logic [LEN_W-1:0]  rem_next;

  // Continuation beat type: SEQ inside an INCR burst unless the address starts a
  // new 1KB region, where AHB forbids SEQ.
  function automatic logic [1:0] beat_type(input logic incr, input logic [ADDR_W-1:0] a);
    return (incr && (a[9:0] != 10'd0)) ? HTRANS_SEQ : HTRANS_NONSEQ;
  endfunction

  assign in_xfer   = (state_q == S_ADDR) || (state_q == S_BURST) || (state_q == S_LAST);
  assign accept    = ((state_q == S_ADDR) || (state_q == S_BURST)) &&
                     ((htrans_q == HTRANS_NONSEQ) || (htrans_q == HTRANS_SEQ)) && bus.HREADY;
  // First cycle of the two-cycle ERROR response.
  assign err_first = in_xfer && dph_q && (bus.HRESP == RESP_ERROR) && !bus.HREADY;
  assign next_addr = haddr_q + ADDR_W'(4);
  assign rem_next  = rem_q - LEN_W'(1);

  always_comb begin
    state_d    = state_q;
    haddr_d    = haddr_q;
    htrans_d   = htrans_q;
    hburst_d   = hburst_q;
    hwrite_d   = hwrite_q;
    hwdata_d   = hwdata_q;
    rem_d      = rem_q;
    incr_d     = incr_q;
    dph_d      = dph_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    // Data phase retires on every HREADY edge; a newly accepted address takes its place.
    if (in_xfer && bus.HREADY) begin
      dph_d = accept;
      if (dph_q && !hwrite_q && (bus.HRESP == RESP_OKAY)) begin
        rd_valid_d = 1'b1;
        rd_data_d  = bus.HRDATA;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            haddr_d  = cmd_addr & ~ADDR_W'(3);
            rem_d    = cmd_len;
            incr_d   = cmd_incr;
            hwrite_d = cmd_write;
            hburst_d = cmd_incr ? HBURST_INCR : HBURST_SINGLE;
            htrans_d = HTRANS_NONSEQ;
            state_d  = S_ADDR;
          end
        end
      end

      S_ADDR, S_BURST: begin
        if (err_first) begin
          htrans_d = HTRANS_IDLE;
          state_d  = S_ERR1;
        end else if (bus.HREADY) begin
          if (htrans_q == HTRANS_BUSY) begin
            // HADDR already points at the next beat; leave BUSY once pause drops.
            if (!(pause && (rem_q != '0))) begin
              htrans_d = beat_type(incr_q, haddr_q);
            end
          end else begin
            haddr_d = next_addr;
            rem_d   = rem_next;
            if (hwrite_q) begin
              hwdata_d = wr_data;
            end
            if (rem_next == '0) begin
              htrans_d = HTRANS_IDLE;
              state_d  = S_LAST;
            end else if ((state_q == S_BURST) && incr_q && pause) begin
              htrans_d = HTRANS_BUSY;
              state_d  = S_BURST;
            end else begin
              htrans_d = beat_type(incr_q, next_addr);
              state_d  = S_BURST;
            end
          end
        end
      end

      S_LAST: begin
        if (err_first) begin
          state_d = S_ERR1;
        end else if (bus.HREADY) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end

      S_ERR1: begin
        // Second ERROR cycle completes the failed beat; remaining beats are dropped.
        dph_d   = 1'b0;
        state_d = S_DONE;
        done_d  = 1'b1;
        err_d   = 1'b1;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q    <= S_IDLE;
      haddr_q    <= '0;
      htrans_q   <= HTRANS_IDLE;
      hburst_q   <= HBURST_SINGLE;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
      rem_q      <= '0;
      incr_q     <= 1'b0;
      dph_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      haddr_q    <= haddr_d;
      htrans_q   <= htrans_d;
      hburst_q   <= hburst_d;
      hwrite_q   <= hwrite_d;
      hwdata_q   <= hwdata_d;
      rem_q      <= rem_d;
      incr_q     <= incr_d;
      dph_q      <= dph_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && HRESETn;
  // wr_data is consumed on the same edge that accepts the write address phase.
  assign wr_pop    = accept && hwrite_q && HRESETn;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign err       = err_q;

  assign bus.HADDR  = haddr_q;
  assign bus.HTRANS = htrans_q;
  assign bus.HBURST = hburst_q;
  assign bus.HSIZE  = 3'b010;
  assign bus.HWRITE = hwrite_q;
  assign bus.HWDATA = hwdata_q;

endmodule
